// File: rtl/ram_pkg.sv
// Shared RAM geometry defaults and the BIST state encoding.
package ram_pkg;

  localparam int ADDR_W_DEF = 6;
  localparam int DATA_W_DEF = 8;
  localparam logic [7:0] PATTERN_DEF = 8'h55;
  localparam int RAM_DEPTH = 2 ** ADDR_W_DEF;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_W_UP,
    ST_RW_UP,
    ST_R_DOWN,
    ST_DONE
  } bist_state_t;

endpackage

// File: rtl/bist_addr_ctr.sv
// Up/down address counter with synchronous load and a direction-aware terminal flag.
module bist_addr_ctr
  import ram_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [ADDR_W-1:0] load_val,
  input  logic              en,
  input  logic              up,
  output logic [ADDR_W-1:0] count,
  output logic              tc
);

  localparam logic [ADDR_W-1:0] CNT_MAX = '1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (en) begin
      count <= up ? count + 1'b1 : count - 1'b1;
    end
  end

  // Terminal value depends on direction so phase ends never rely on wrap-around.
  assign tc = up ? (count == CNT_MAX) : (count == '0);

endmodule

// File: rtl/ram_bist.sv
// March-test BIST for a single-port RAM: write P up, read P / write ~P up,
// read ~P down; reports pass/fail with the first failing address and data.
module ram_bist
  import ram_pkg::*;
#(
  parameter int                ADDR_W  = ADDR_W_DEF,
  parameter int                DATA_W  = DATA_W_DEF,
  parameter logic [DATA_W-1:0] PATTERN = PATTERN_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [ADDR_W-1:0] fail_addr,
  output logic [DATA_W-1:0] fail_data,
  output logic [DATA_W-1:0] mem_data,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_out
);

  localparam logic [DATA_W-1:0] PATTERN_N = ~PATTERN;
  localparam logic [ADDR_W-1:0] ADDR_MAX  = '1;

  bist_state_t       state_reg;
  logic              phase_reg;
  logic              first_reg;
  logic              drain_reg;
  logic [ADDR_W-1:0] cmp_addr_reg;

  logic              ctr_load;
  logic [ADDR_W-1:0] ctr_load_val;
  logic              ctr_en;
  logic              ctr_up;
  logic [ADDR_W-1:0] ctr_count;
  logic              ctr_tc;
  logic              rw_miss;
  logic              rd_miss;

  // The counter register is the RAM address register itself.
  bist_addr_ctr #(.ADDR_W(ADDR_W)) u_ctr (
    .clk      (clk),
    .rst      (rst),
    .load     (ctr_load),
    .load_val (ctr_load_val),
    .en       (ctr_en),
    .up       (ctr_up),
    .count    (ctr_count),
    .tc       (ctr_tc)
  );

  assign mem_addr = ctr_count;
  assign rw_miss  = (mem_out != PATTERN);
  assign rd_miss  = (mem_out != PATTERN_N);

  always_comb begin
    ctr_load     = 1'b0;
    ctr_load_val = '0;
    ctr_en       = 1'b0;
    ctr_up       = 1'b1;
    case (state_reg)
      ST_IDLE, ST_DONE: ctr_load = start;
      ST_W_UP: begin
        if (ctr_tc) ctr_load = 1'b1;
        else        ctr_en   = 1'b1;
      end
      ST_RW_UP: begin
        if (phase_reg) begin
          if (rw_miss) begin
            ctr_load = 1'b1;
          end else if (ctr_tc) begin
            ctr_load     = 1'b1;
            ctr_load_val = ADDR_MAX;
          end else begin
            ctr_en = 1'b1;
          end
        end
      end
      ST_R_DOWN: begin
        ctr_up = 1'b0;
        if (drain_reg || (!first_reg && rd_miss)) ctr_load = 1'b1;
        else if (!ctr_tc)                         ctr_en   = 1'b1;
      end
      default: ctr_load = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= ST_IDLE;
      phase_reg    <= 1'b0;
      first_reg    <= 1'b0;
      drain_reg    <= 1'b0;
      cmp_addr_reg <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      pass         <= 1'b0;
      fail_addr    <= '0;
      fail_data    <= '0;
      mem_we       <= 1'b0;
      mem_data     <= '0;
    end else begin
      case (state_reg)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            state_reg <= ST_W_UP;
            busy      <= 1'b1;
            done      <= 1'b0;
            pass      <= 1'b0;
            fail_addr <= '0;
            fail_data <= '0;
            mem_we    <= 1'b1;
            mem_data  <= PATTERN;
          end
        end
        ST_W_UP: begin
          if (ctr_tc) begin
            state_reg <= ST_RW_UP;
            phase_reg <= 1'b0;
            mem_we    <= 1'b0;
            mem_data  <= '0;
          end
        end
        ST_RW_UP: begin
          if (!phase_reg) begin
            phase_reg <= 1'b1;
            mem_we    <= 1'b1;
            mem_data  <= PATTERN_N;
          end else begin
            // The ~P write for this address is already on the port and lands regardless.
            phase_reg <= 1'b0;
            mem_we    <= 1'b0;
            mem_data  <= '0;
            if (rw_miss) begin
              state_reg <= ST_DONE;
              busy      <= 1'b0;
              done      <= 1'b1;
              pass      <= 1'b0;
              fail_addr <= ctr_count;
              fail_data <= mem_out;
            end else if (ctr_tc) begin
              state_reg <= ST_R_DOWN;
              first_reg <= 1'b1;
              drain_reg <= 1'b0;
            end
          end
        end
        ST_R_DOWN: begin
          cmp_addr_reg <= ctr_count;
          first_reg    <= 1'b0;
          if (!first_reg && rd_miss) begin
            state_reg <= ST_DONE;
            busy      <= 1'b0;
            done      <= 1'b1;
            pass      <= 1'b0;
            fail_addr <= cmp_addr_reg;
            fail_data <= mem_out;
          end else if (drain_reg) begin
            state_reg <= ST_DONE;
            busy      <= 1'b0;
            done      <= 1'b1;
            pass      <= 1'b1;
            drain_reg <= 1'b0;
          end else if (ctr_tc) begin
            drain_reg <= 1'b1;
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_bist.sv
// Directed bench for ram_bist: cycle schedule, fault detection, restart and reset.
module tb_ram_bist;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       start2;
  int         fault;
  int         n_cmp = 0;
  int         n_err = 0;
  int         k_done;

  logic       busy_a, done_a, pass_a, mem_we_a;
  logic [5:0] fail_addr_a, mem_addr_a;
  logic [7:0] fail_data_a, mem_data_a, mem_out_a;
  logic       busy_b, done_b, pass_b, mem_we_b;
  logic [5:0] fail_addr_b, mem_addr_b;
  logic [7:0] fail_data_b, mem_data_b, mem_out_b;

  logic [7:0] ram_a [64];
  logic [7:0] ram_b [64];
  logic [5:0] rq_a, rq_b;

  always #5 clk = ~clk;

  ram_bist dut_a (
    .clk(clk), .rst(rst), .start(start), .busy(busy_a), .done(done_a), .pass(pass_a),
    .fail_addr(fail_addr_a), .fail_data(fail_data_a), .mem_data(mem_data_a),
    .mem_addr(mem_addr_a), .mem_we(mem_we_a), .mem_out(mem_out_a)
  );

  ram_bist #(.PATTERN(8'hF0)) dut_b (
    .clk(clk), .rst(rst), .start(start2), .busy(busy_b), .done(done_b), .pass(pass_b),
    .fail_addr(fail_addr_b), .fail_data(fail_data_b), .mem_data(mem_data_b),
    .mem_addr(mem_addr_b), .mem_we(mem_we_b), .mem_out(mem_out_b)
  );

  // RAM A: fault 1 reads bit 0 of 0x2A as 0; fault 2 drops ~P (0xAA) writes to 0x10.
  always @(posedge clk) begin
    if (mem_we_a && !(fault == 2 && mem_addr_a == 6'h10 && mem_data_a == 8'hAA))
      ram_a[mem_addr_a] <= mem_data_a;
    rq_a <= mem_addr_a;
  end
  assign mem_out_a = (fault == 1 && rq_a == 6'h2A) ? (ram_a[rq_a] & 8'hFE) : ram_a[rq_a];

  always @(posedge clk) begin
    if (mem_we_b) ram_b[mem_addr_b] <= mem_data_b;
    rq_b <= mem_addr_b;
  end
  assign mem_out_b = ram_b[rq_b];

  function automatic logic [31:0] outs_a();
    return {busy_a, done_a, pass_a, fail_addr_a, fail_data_a, mem_we_a, mem_addr_a, mem_data_a};
  endfunction

  function automatic logic [31:0] outs_b();
    return {busy_b, done_b, pass_b, fail_addr_b, fail_data_b, mem_we_b, mem_addr_b, mem_data_b};
  endfunction

  // Expected {busy, done, we, addr, data} for busy cycle k of a 64-entry test.
  function automatic logic [31:0] sched(input int k, input logic [7:0] p);
    logic       we;
    logic [5:0] a;
    logic [7:0] d;
    if (k <= 64) begin
      we = 1'b1; a = 6'(k - 1); d = p;
    end else if (k <= 192) begin
      a  = 6'((k - 65) / 2);
      we = (((k - 65) % 2) == 1);
      d  = we ? ~p : 8'h00;
    end else if (k <= 256) begin
      we = 1'b0; a = 6'(63 - (k - 193)); d = 8'h00;
    end else begin
      we = 1'b0; a = 6'h00; d = 8'h00;
    end
    return {15'h0, 1'b1, 1'b0, we, a, d};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic run_full(input int extra, input bit with_b);
    start = 1'b1;
    if (with_b) start2 = 1'b1;
    @(negedge clk);
    start  = 1'b0;
    start2 = 1'b0;
    for (int k = 1; k <= 257; k++) begin
      chk($sformatf("sched_a_c%0d", k),
          {15'h0, busy_a, done_a, mem_we_a, mem_addr_a, mem_data_a}, sched(k, 8'h55));
      if (with_b)
        chk($sformatf("sched_b_c%0d", k),
            {15'h0, busy_b, done_b, mem_we_b, mem_addr_b, mem_data_b}, sched(k, 8'hF0));
      start = (k == extra);
      @(negedge clk);
    end
    start = 1'b0;
    chk("result_a", outs_a(), {1'b0, 1'b1, 1'b1, 29'h0});
    if (with_b) chk("result_b", outs_b(), {1'b0, 1'b1, 1'b1, 29'h0});
    $display("run full extra_start=%0d with_b=%0d pass_a=%0b errors=%0d", extra, with_b, pass_a, n_err);
  endtask

  task automatic run_fault(input int f, input int exp_cycle, input logic [5:0] ea,
                           input logic [7:0] ed);
    fault = f;
    start = 1'b1;
    @(negedge clk);
    start  = 1'b0;
    k_done = 0;
    for (int k = 1; k <= 300; k++) begin
      if (done_a) begin
        k_done = k;
        break;
      end
      @(negedge clk);
    end
    chk($sformatf("fault%0d_done_cycle", f), 32'(k_done), 32'(exp_cycle));
    chk($sformatf("fault%0d_result", f), outs_a(), {1'b0, 1'b1, 1'b0, ea, ed, 15'h0});
    $display("run fault=%0d done_cycle=%0d fail_addr=%0h fail_data=%0h", f, k_done, fail_addr_a, fail_data_a);
  endtask

  initial begin
    rst    = 1'b1;
    start  = 1'b0;
    start2 = 1'b0;
    fault  = 0;
    repeat (2) @(negedge clk);
    chk("reset_a", outs_a(), 32'h0);
    chk("reset_b", outs_b(), 32'h0);
    rst = 1'b0;
    @(negedge clk);

    // Clean run on both instances, including the PATTERN=F0 one.
    run_full(0, 1'b1);
    chk("ram_b_0f", 32'(ram_b[5]), 32'h0F);
    chk("ram_a_aa", 32'(ram_a[63]), 32'hAA);

    // Restart from DONE with an ignored start at c50.
    run_full(50, 1'b0);

    // Compare fails in RW_UP at c150; the ~P write there still lands.
    run_fault(1, 151, 6'h2A, 8'h54);
    chk("ram_2a_written", 32'(ram_a[6'h2A]), 32'hAA);

    // Compare of 0x10 in R_DOWN runs at c241.
    run_fault(2, 242, 6'h10, 8'h55);

    // Asynchronous reset mid-test, then a full passing run.
    fault = 0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (99) @(negedge clk);
    chk("busy_before_rst", {31'h0, busy_a}, 32'h1);
    #1 rst = 1'b1;
    #1 chk("async_reset", outs_a(), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_after_rst", outs_a(), 32'h0);
    run_full(0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
